yarp_mem_arb: RTL

Two-port memory arbiter that shares the single data/instruction memory port between the instruction-fetch unit and the load/store path. It accepts one request at a time from either requester, sequences it onto the memory bus with a request/grant/response handshake, and routes the response back to the owner. Data has priority, with a streak counter that bounds fetch starvation. One transaction is outstanding at a time.

---
 rtl/yarp_pkg.sv | 31 +++
 rtl/yarp_mem_arb.sv | 123 ++++++++++++
 2 files changed

// File: rtl/yarp_pkg.sv
// Shared types and constants for the yarp memory arbiter.
package yarp_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned SIZE_W = 2;

  // Access-size encodings carried on byte_en.
  localparam logic [SIZE_W-1:0] BYTE      = 2'b00;
  localparam logic [SIZE_W-1:0] HALF_WORD = 2'b01;
  localparam logic [SIZE_W-1:0] WORD      = 2'b11;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ADDR,
    ARB_RESP
  } arb_state_e;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } arb_owner_e;

  // Attributes of one memory transaction as presented on the mem_* bus.
  typedef struct packed {
    logic [XLEN-1:0]   addr;
    logic [SIZE_W-1:0] byte_en;
    logic              wr;
    logic [XLEN-1:0]   wr_data;
  } mem_txn_t;

endpackage

// File: rtl/yarp_mem_arb.sv
// Shares the single memory port between instruction fetch and load/store.
// Data has priority; a streak counter lets fetch win after a bounded run
// of data grants. One transaction is outstanding at a time.
module yarp_mem_arb
  import yarp_pkg::*;
#(
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              if_req_i,
  input  logic [XLEN-1:0]   if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [XLEN-1:0]   if_rdata_o,

  input  logic              dm_req_i,
  input  logic [XLEN-1:0]   dm_addr_i,
  input  logic [SIZE_W-1:0] dm_byte_en_i,
  input  logic              dm_wr_i,
  input  logic [XLEN-1:0]   dm_wr_data_i,
  output logic              dm_gnt_o,
  output logic              dm_rvalid_o,
  output logic [XLEN-1:0]   dm_rdata_o,

  output logic              mem_req_o,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [SIZE_W-1:0] mem_byte_en_o,
  output logic              mem_wr_o,
  output logic [XLEN-1:0]   mem_wr_data_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i
);

  localparam int unsigned STREAK_W = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  arb_state_e            state_q, state_d;
  arb_owner_e            owner_q;
  arb_owner_e            win;
  logic                  grant;
  logic [STREAK_W-1:0]   streak_q;
  mem_txn_t              txn_q;

  // Data wins unless fetch is also waiting and data has used up its streak.
  function automatic arb_owner_e sel_owner(input logic                if_req,
                                           input logic                dm_req,
                                           input logic [STREAK_W-1:0] streak);
    if (dm_req && !(if_req && (streak == STREAK_MAX))) return OWN_DM;
    return OWN_IF;
  endfunction

  // Next-state, grant and response routing.
  always_comb begin
    state_d     = state_q;
    grant       = 1'b0;
    if_gnt_o    = 1'b0;
    dm_gnt_o    = 1'b0;
    if_rvalid_o = 1'b0;
    dm_rvalid_o = 1'b0;
    win         = sel_owner(if_req_i, dm_req_i, streak_q);
    case (state_q)
      ARB_IDLE: begin
        if (if_req_i || dm_req_i) begin
          grant    = 1'b1;
          if_gnt_o = (win == OWN_IF);
          dm_gnt_o = (win == OWN_DM);
          state_d  = ARB_ADDR;
        end
      end
      ARB_ADDR: begin
        if (mem_gnt_i) state_d = ARB_RESP;
      end
      ARB_RESP: begin
        if (mem_rvalid_i) begin
          if_rvalid_o = (owner_q == OWN_IF);
          dm_rvalid_o = (owner_q == OWN_DM);
          state_d     = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ARB_IDLE;
    else        state_q <= state_d;
  end

  // Capture owner, transaction attributes and streak on each grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q  <= OWN_IF;
      streak_q <= '0;
      txn_q    <= '0;
    end else if (grant) begin
      owner_q <= win;
      if (win == OWN_IF) begin
        txn_q    <= '{addr: if_addr_i, byte_en: WORD, wr: 1'b0, wr_data: '0};
        streak_q <= '0;
      end else begin
        txn_q    <= '{addr: dm_addr_i, byte_en: dm_byte_en_i, wr: dm_wr_i,
                      wr_data: dm_wr_data_i};
        if (!if_req_i)                streak_q <= '0;
        else if (streak_q != STREAK_MAX) streak_q <= streak_q + STREAK_W'(1);
      end
    end
  end

  assign mem_req_o     = (state_q == ARB_ADDR);
  assign mem_addr_o    = txn_q.addr;
  assign mem_byte_en_o = txn_q.byte_en;
  assign mem_wr_o      = txn_q.wr;
  assign mem_wr_data_o = txn_q.wr_data;

  // Read data is broadcast; only the rvalids select the owner.
  assign if_rdata_o = mem_rdata_i;
  assign dm_rdata_o = mem_rdata_i;

endmodule
